mul_div_unit: RTL and testbench

Parametrised, iterative multiply/divide unit that extends the single-cycle `alu` datapath with the RISC-V M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus RV64 word (`*W`) variants. It sits beside the `alu` in the execute stage. The issue logic hands it one operation through a valid/ready handshake, stalls until the result is returned, and then consumes the result through a second valid/ready handshake. The unit computes one bit per cycle, using shift-add multiplication and restoring division, and handles divide-by-zero and signed overflow as fast paths.

---
 rtl/mul_div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the RISC-V M extension, including the
// RV64 word variants. Computes one bit per cycle: shift-add multiplication
// and restoring division. Divide-by-zero and signed overflow are fast paths
// that skip the iteration.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operation request handshake (ready only in IDLE)
//   op                  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   op_word             word mode for MUL and the divide group
//   a, b                operands rs1, rs2
//   out_valid/out_ready result handshake (valid only in DONE)
//   result              registered result
//   div_by_zero         completed divide/remainder had a zero divisor
//   overflow            completed signed divide/remainder was MIN / -1
module mul_div_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             op_word,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             word_q;
  logic             neg_q;      // negate product / quotient in FIX
  logic             neg_rem_q;  // negate remainder in FIX (dividend sign)
  logic             dbz_q;
  logic             ovf_q;
  logic [WIDTH-1:0] opb;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi;         // product high half / partial remainder
  logic [WIDTH-1:0] lo;         // multiplier being shifted out / quotient

  // Accept-time operand decoding
  logic             accept;
  logic             is_div;
  logic             signed_a;
  logic             signed_b;
  logic             word_in;
  logic [WIDTH-1:0] ext_a;
  logic [WIDTH-1:0] ext_b;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] min_val;
  logic             zero_b;
  logic             ovf_in;
  logic             fast_in;

  // Iteration and finalisation
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   raw;
  logic [WIDTH-1:0]   fixed;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    is_div   = op[2];
    signed_a = is_div ? ~op[0] : (op == 3'b001 || op == 3'b010);
    signed_b = is_div ? ~op[0] : (op == 3'b001);
    word_in  = op_word && (is_div || op == 3'b000);

    ext_a = a;
    ext_b = b;
    if (word_in) begin
      ext_a = {{HALF{signed_a & a[HALF-1]}}, a[HALF-1:0]};
      ext_b = {{HALF{signed_b & b[HALF-1]}}, b[HALF-1:0]};
    end

    neg_a = signed_a & ext_a[WIDTH-1];
    neg_b = signed_b & ext_b[WIDTH-1];
    mag_a = neg_a ? -ext_a : ext_a;
    mag_b = neg_b ? -ext_b : ext_b;

    // Most negative value of the active width, already sign-extended
    min_val = word_in ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}}
                      : {1'b1, {(WIDTH-1){1'b0}}};
    zero_b  = (ext_b == '0);
    ovf_in  = is_div && signed_a && (ext_a == min_val) && (ext_b == '1);
    fast_in = is_div && (zero_b || ovf_in);
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_trial = {hi, lo[WIDTH-1]} - {1'b0, opb};

    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    quo_fix  = neg_q ? -lo : lo;
    rem_fix  = neg_rem_q ? -hi : hi;

    case (op_q)
      3'b000:                 raw = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: raw = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         raw = quo_fix;
      default:                raw = rem_fix;
    endcase

    fixed = word_q ? {{HALF{raw[HALF-1]}}, raw[HALF-1:0]} : raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = fast_in ? FIX : CALC;
      CALC: if (cnt == LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      opb         <= '0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op;
            word_q <= word_in;
            cnt    <= '0;
            dbz_q  <= is_div && zero_b;
            ovf_q  <= ovf_in && !zero_b;
            // Fast paths preload the final quotient/remainder so that FIX
            // selects them exactly like an iterated divide result.
            if (is_div && zero_b) begin
              lo        <= '1;
              hi        <= ext_a;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
            end else if (ovf_in) begin
              lo        <= min_val;
              hi        <= '0;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
            end else if (is_div) begin
              lo        <= mag_a;
              hi        <= '0;
              opb       <= mag_b;
              neg_q     <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
            end else begin
              lo        <= mag_b;
              hi        <= '0;
              opb       <= mag_a;
              neg_q     <= neg_a ^ neg_b;
              neg_rem_q <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
              hi <= div_trial[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          result      <= fixed;
          div_by_zero <= dbz_q;
          overflow    <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic          op_word;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          div_by_zero;
  logic          overflow;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    logic         ovf;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .op_word    (op_word),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // Scoreboard: every result handed off is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: result=%h with nothing outstanding", result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || div_by_zero !== mon_e.dbz || overflow !== mon_e.ovf) begin
          errors++;
          $display("FAIL %s: got result=%h dbz=%b ovf=%b, expected result=%h dbz=%b ovf=%b",
                   mon_e.name, result, div_by_zero, overflow, mon_e.res, mon_e.dbz, mon_e.ovf);
        end
      end
    end
  end

  // Reference model built on native arithmetic
  function automatic void model(input logic [2:0] o, input logic w,
                                input logic [W-1:0] x_in, input logic [W-1:0] y_in,
                                output logic [W-1:0] r, output logic d, output logic v);
    logic [2*W-1:0]      p;
    logic [W-1:0]        x, y, q, rm;
    logic signed [W-1:0] sx, sy;
    logic                sgn;
    sgn = (o == 3'b100) || (o == 3'b110);
    d = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      3'b000: begin p = {64'b0, x_in} * {64'b0, y_in}; r = p[W-1:0]; end
      3'b001: begin p = {{64{x_in[63]}}, x_in} * {{64{y_in[63]}}, y_in}; r = p[2*W-1:W]; end
      3'b010: begin p = {{64{x_in[63]}}, x_in} * {64'b0, y_in}; r = p[2*W-1:W]; end
      3'b011: begin p = {64'b0, x_in} * {64'b0, y_in}; r = p[2*W-1:W]; end
      default: begin
        x = x_in;
        y = y_in;
        if (w) begin
          x = {{32{sgn & x_in[31]}}, x_in[31:0]};
          y = {{32{sgn & y_in[31]}}, y_in[31:0]};
        end
        if (y == 0) begin
          q = '1; rm = x; d = 1'b1;
        end else if (sgn && y == '1 &&
                     x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
          q = x; rm = '0; v = 1'b1;
        end else if (sgn) begin
          sx = x; sy = y;
          q = sx / sy; rm = sx % sy;
        end else begin
          q = x / y; rm = x % y;
        end
        r = o[1] ? rm : q;
      end
    endcase
    if (w && (o == 3'b000 || o[2])) r = {{32{r[31]}}, r[31:0]};
  endfunction

  task automatic send(input logic [2:0] o, input logic w, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] er, input logic ed,
                      input logic eo, input string nm);
    exp_t e;
    e.res = er; e.dbz = ed; e.ovf = eo; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    op = o; op_word = w; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges after accept until out_valid is seen (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 300);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; op_word = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/dbz/ovf=%b, expected 1000",
               {in_ready, out_valid, div_by_zero, overflow});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h, expected 0", result);
    end
  endtask

  task automatic test_mul_latency;
    int n;
    int busy_ready;
    busy_ready = 0;
    n = 0;
    send(3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, "mul_7_m3");
    do begin
      @(posedge clk); #1; n++;
      if (in_ready) busy_ready++;
    end while (!out_valid && n < 300);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL mul_latency: got %0d edges, expected 65", n);
    end
    checks++;
    if (busy_ready !== 0) begin
      errors++;
      $display("FAIL mul_in_ready_busy: in_ready high %0d cycles, expected 0", busy_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_high_products;
    int n;
    send(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "mulhu_ones");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL mulhu_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
    send(3'b001, 1'b0, '1, '1, 64'h0, 1'b0, 1'b0, "mulh_m1_m1");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL mulh_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
    send(3'b010, 1'b0, '1, '1, '1, 1'b0, 1'b0, "mulhsu_m1_ones");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL mulhsu_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_divide;
    int n;
    send(3'b100, 1'b0, -64'sd7, 64'd2, -64'sd3, 1'b0, 1'b0, "div_m7_2");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL div_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
    send(3'b110, 1'b0, -64'sd7, 64'd2, -64'sd1, 1'b0, 1'b0, "rem_m7_2");
    wait_valid(n);
    @(posedge clk); #1;
    send(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, "divu_100_7");
    wait_valid(n);
    @(posedge clk); #1;
    send(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, "remu_100_7");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL remu_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_fast_paths;
    int n;
    send(3'b101, 1'b0, 64'd5, 64'd0, '1, 1'b1, 1'b0, "divu_5_0");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL divu_zero_latency: got %0d, expected 1", n); end
    @(posedge clk); #1;
    send(3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 1'b0, "rem_5_0");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL rem_zero_latency: got %0d, expected 1", n); end
    @(posedge clk); #1;
    send(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
         "div_min_m1");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d, expected 1", n); end
    @(posedge clk); #1;
    send(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1'b0, 1'b1, "rem_min_m1");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL rem_ovf_latency: got %0d, expected 1", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_word_mode;
    int n;
    send(3'b100, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1,
         "divw_min_m1");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL divw_ovf_latency: got %0d, expected 1", n); end
    @(posedge clk); #1;
    send(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "mulw");
    wait_valid(n);
    @(posedge clk); #1;
    send(3'b101, 1'b1, 64'h1234_5678_0000_0010, 64'd4, 64'd4, 1'b0, 1'b0, "divuw");
    wait_valid(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL divuw_latency: got %0d, expected 65", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    int unstable;
    unstable = 0;
    out_ready = 1'b0;
    send(3'b101, 1'b0, 64'd5, 64'd0, '1, 1'b1, 1'b0, "divu_5_0_held");
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL held_latency: got %0d, expected 1", n); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== '1 || div_by_zero !== 1'b1 || overflow !== 1'b0)
        unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, expected 0", unstable);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handoff: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    stale = 0;
    send(3'b100, 1'b0, -64'sd7, 64'd2, -64'sd3, 1'b0, 1'b0, "aborted");
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 ||
        div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b result=%h, expected rdy=1 vld=0 result=0",
               in_ready, out_valid, result);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL after_reset: got rdy=%b vld=%b result=%h, expected rdy=1 vld=0 result=0",
               in_ready, out_valid, result);
    end
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_result: out_valid high %0d cycles, expected 0", stale);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int exp_n;
    logic [2:0]   o;
    logic         w;
    logic [W-1:0] x, y, er;
    logic         ed, eo;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      x = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: y = 64'd0;
        1: y = 64'($urandom_range(1, 20));
        2: y = '1;
        default: y = {$urandom(), $urandom()};
      endcase
      if (i == 0) begin o = 3'b110; w = 1'b1; x = 64'h0000_0001_8000_0000; y = '1; end
      model(o, w, x, y, er, ed, eo);
      exp_n = (ed || eo) ? 1 : 65;
      send(o, w, x, y, er, ed, eo, $sformatf("rand%0d_op%0d_w%0d", i, o, w));
      wait_valid(n);
      checks++;
      if (n !== exp_n) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d, expected %0d", i, n, exp_n);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_high_products();
    test_divide();
    test_fast_paths();
    test_word_mode();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL outstanding: %0d results never produced, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
